// File: rtl/pc_redirect_pkg.sv
// Shared constants for the stage-1 PC generator: reset fetch address,
// controller state encoding and the sequential PC increment.
package pc_redirect_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
    localparam int unsigned PC_INC           = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencing FSM for the PC generator.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   BOOT  | first fetch held until the pipeline is allowed to move
//   RUN   | normal sequential fetch; a qualified jump redirects now
//   PEND  | a jump arrived under stall; latched target applied on release
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic take,
    input  logic stall,
    output logic advance,
    output logic apply_redirect,
    output logic use_pending,
    output logic latch_pending,
    output logic booting
);

    state_t state;
    state_t state_nxt;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: if (!stall)        state_nxt = ST_RUN;
            ST_RUN:  if (take && stall) state_nxt = ST_PEND;
            ST_PEND: if (!stall)        state_nxt = ST_RUN;
            default:                    state_nxt = ST_BOOT;
        endcase
    end

    // Datapath control strobes; PEND deliberately ignores take
    always_comb begin
        advance        = 1'b0;
        apply_redirect = 1'b0;
        use_pending    = 1'b0;
        latch_pending  = 1'b0;
        booting        = 1'b0;
        case (state)
            ST_BOOT: begin
                advance = !stall;
                booting = 1'b1;
            end
            ST_RUN: begin
                advance        = !stall;
                apply_redirect = take && !stall;
                latch_pending  = take && stall;
            end
            ST_PEND: begin
                advance     = !stall;
                use_pending = !stall;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_redirect.sv
// Stage-1 PC generator: fetch address, stage-2 PC, wrong-path kill bubble,
// stall-tolerant redirect and a free-running redirect counter.
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_x,
    output logic            kill_x,
    output logic [31:0]     redirect_cnt
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            take;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pend_target;
    logic [31:0]     cnt_q;
    logic            advance;
    logic            apply_redirect;
    logic            use_pending;
    logic            latch_pending;
    logic            booting;

    // A jump from a bubble is never honoured; the target is forced word aligned
    assign take         = jump & ~kill_x;
    assign target       = jump_target & ALIGN_MASK;
    assign redirect_cnt = cnt_q;

    pc_redirect_ctrl u_ctrl (
        .clk            (clk),
        .reset_n        (reset_n),
        .take           (take),
        .stall          (stall),
        .advance        (advance),
        .apply_redirect (apply_redirect),
        .use_pending    (use_pending),
        .latch_pending  (latch_pending),
        .booting        (booting)
    );

    // PC pipeline, kill bubble, latched target and redirect counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_f        <= RESET_PC;
            pc_x        <= RESET_PC - XLEN'(PC_INC);
            kill_x      <= 1'b1;
            cnt_q       <= 32'd0;
            pend_target <= '0;
        end else begin
            if (advance) begin
                pc_x   <= pc_f;
                kill_x <= apply_redirect | use_pending | booting;
                if (apply_redirect) begin
                    pc_f <= target;
                end else if (use_pending) begin
                    pc_f <= pend_target;
                end else begin
                    pc_f <= pc_f + XLEN'(PC_INC);
                end
            end
            if (apply_redirect || use_pending) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (latch_pending) begin
                pend_target <= target;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect.sv
// Directed test of the stage-1 PC generator.
module tb_pc_redirect;
    import pc_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_f;
    logic [31:0] pc_x;
    logic        kill_x;
    logic [31:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    pc_redirect dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_f         (pc_f),
        .pc_x         (pc_x),
        .kill_x       (kill_x),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_pcx,
                             input logic e_kill, input logic [31:0] e_cnt);
        check({tag, ".pc_f"}, pc_f, e_pcf);
        check({tag, ".pc_x"}, pc_x, e_pcx);
        check({tag, ".kill_x"}, {31'd0, kill_x}, {31'd0, e_kill});
        check({tag, ".cnt"}, redirect_cnt, e_cnt);
    endtask

    task automatic check_state(input string tag, input state_t e_st);
        check({tag, ".state"}, {30'd0, dut.u_ctrl.state}, {30'd0, e_st});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        jump        = 1'b0;
        jump_target = 32'h0;
        step();
        step();
        check_all("reset", 32'h2000, 32'h1FFC, 1'b1, 32'd0);
        check_state("reset", ST_BOOT);

        // Boot sequence
        reset_n = 1'b1;
        check_all("boot1", 32'h2000, 32'h1FFC, 1'b1, 32'd0);
        step(); check_all("boot2", 32'h2004, 32'h2000, 1'b1, 32'd0);
        check_state("boot2", ST_RUN);
        step(); check_all("boot3", 32'h2008, 32'h2004, 1'b0, 32'd0);
        step(); check_all("run4", 32'h200C, 32'h2008, 1'b0, 32'd0);
        step(); check_all("run5", 32'h2010, 32'h200C, 1'b0, 32'd0);

        // Simple redirect, target low bits dropped
        jump = 1'b1; jump_target = 32'h3002;
        step(); check_all("redir1", 32'h3000, 32'h2010, 1'b1, 32'd1);

        // Jump from the bubble is ignored
        jump = 1'b1; jump_target = 32'h4000;
        step(); check_all("killed", 32'h3004, 32'h3000, 1'b0, 32'd1);
        jump = 1'b0;
        step(); check_all("run6", 32'h3008, 32'h3004, 1'b0, 32'd1);

        // Redirect under a 3-cycle stall; later jump/target changes ignored
        jump = 1'b1; jump_target = 32'h5000; stall = 1'b1;
        step(); check_all("stall1", 32'h3008, 32'h3004, 1'b0, 32'd1);
        check_state("stall1", ST_PEND);
        jump = 1'b0; jump_target = 32'h6000;
        step(); check_all("stall2", 32'h3008, 32'h3004, 1'b0, 32'd1);
        check_state("stall2", ST_PEND);
        jump = 1'b1;
        step(); check_all("stall3", 32'h3008, 32'h3004, 1'b0, 32'd1);
        check_state("stall3", ST_PEND);
        jump = 1'b0; stall = 1'b0;
        step(); check_all("pend_apply", 32'h5000, 32'h3008, 1'b1, 32'd2);
        check_state("pend_apply", ST_RUN);
        step(); check_all("pend_after", 32'h5004, 32'h5000, 1'b0, 32'd2);

        // Reset while PEND holds 0x5000
        jump = 1'b1; jump_target = 32'h5000; stall = 1'b1;
        step(); check_state("pend_rst", ST_PEND);
        #2 reset_n = 1'b0;
        #1 check_all("async_rst", 32'h2000, 32'h1FFC, 1'b1, 32'd0);
        check_state("async_rst", ST_BOOT);
        jump = 1'b0;
        step();
        reset_n = 1'b1;
        step(); check_all("boot_stall", 32'h2000, 32'h1FFC, 1'b1, 32'd0);
        check_state("boot_stall", ST_BOOT);
        stall = 1'b0;
        step(); check_all("reboot1", 32'h2004, 32'h2000, 1'b1, 32'd0);
        step(); check_all("reboot2", 32'h2008, 32'h2004, 1'b0, 32'd0);
        step(); check_all("reboot3", 32'h200C, 32'h2008, 1'b0, 32'd0);

        // PC wrap: redirect to top of address space, then sequential step
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step(); check_all("to_top", 32'hFFFF_FFFC, 32'h200C, 1'b1, 32'd1);
        jump = 1'b0;
        step(); check_all("pc_wrap", 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 32'd1);

        // Counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        #1 check("cnt_forced", redirect_cnt, 32'hFFFF_FFFF);
        jump = 1'b1; jump_target = 32'h0000_0100;
        step(); check_all("cnt_wrap", 32'h0000_0100, 32'h0000_0000, 1'b1, 32'd0);
        jump = 1'b0;
        step(); check_all("after_wrap", 32'h0000_0104, 32'h0000_0100, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
Name: pc_redirect

Overview:
Stage-1 PC generator for the 3-stage RV32I pipeline (F / X / MW). It directly consumes the `jump` decision from the stage-2 Jump unit and the stage-2 ALU target. It produces the instruction fetch address, the PC of the instruction entering stage 2, and a kill bubble for the wrong-path instruction. It also holds a redirect across cache stalls and counts applied redirects for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_2000, address fetched in the first cycle after reset.
- XLEN, 32, PC and target width.

Ports:
- clk, input, 1, pipeline clock.
- reset_n, input, 1, asynchronous active-low reset.
- stall, input, 1, global pipeline stall from the I$/D$; freezes all pipeline registers.
- jump, input, 1, redirect request from the stage-2 Jump unit for the instruction currently at pc_x.
- jump_target, input, XLEN, redirect target from the stage-2 ALU.
- pc_f, output, XLEN, fetch address presented to the I$ this cycle.
- pc_x, output, XLEN, PC of the instruction currently in stage 2.
- kill_x, output, 1, stage-2 instruction is a bubble; stage 2 must suppress writes and ignore its `jump`.
- redirect_cnt, output, 32, number of redirects applied since reset.

Behaviour:
- Reset (async assert, sync release): pc_f=RESET_PC, pc_x=RESET_PC-4, kill_x=1, redirect_cnt=0, pend_target=0, state=BOOT.
- Bit 1:0 rule: pc_f, pc_x and pend_target always have [1:0]=2'b00; jump_target[1:0] are dropped. There is no misaligned trap.
- Qualified request: take = jump & ~kill_x. A jump from a killed instruction is ignored in every state.
- Advance: all registers hold when stall=1, except the state and pend_target transitions listed below.
- States:
  - BOOT:
    - Holds the first fetch.
    - When stall=0: pc_x<=pc_f, pc_f<=pc_f+4, kill_x<=1 (no valid instruction in X yet), go to RUN.
    - When stall=1: stay in BOOT.
  - RUN, take=0, stall=0: pc_x<=pc_f, pc_f<=pc_f+4, kill_x<=0.
  - RUN, take=1, stall=0: apply the redirect this cycle.
    - pc_x<=pc_f.
    - pc_f<=target.
    - kill_x<=1 (the fall-through instruction is wrong-path).
    - redirect_cnt<=redirect_cnt+1.
  - RUN, take=1, stall=1: pend_target<=target, go to PEND. pc_f, pc_x and kill_x hold.
  - PEND:
    - Ignores jump and jump_target, even if they change while stalled; the latched target wins.
    - On the first cycle with stall=0: pc_x<=pc_f, pc_f<=pend_target, kill_x<=1, redirect_cnt+1, go to RUN.
- Latency: a redirect requested in cycle t with no stall gives pc_f=target in t+1 and pc_x=target with kill_x=0 in t+2. Each redirect costs exactly one bubble.
- Counter: redirect_cnt is 32-bit and wraps from 0xFFFF_FFFF to 0 silently.
- PC arithmetic: pc_f+4 wraps modulo 2^32 (0xFFFF_FFFC+4 gives 0).
- Reset mid-operation:
  - reset_n low in any state (including PEND) immediately restores all reset values.
  - A pending target is discarded.
- Outputs pc_f, pc_x, kill_x and redirect_cnt come straight from registers. There is no combinational path from jump or stall to any output.

Decomposition:
- Shared package/header (the existing stage constants include): RESET_PC default, the 2-bit state encoding (BOOT=0, RUN=1, PEND=2), and the PC increment constant 4.
- Sub-module: pc_redirect_ctrl, holding the 3-state FSM. Its inputs are take and stall; its outputs are advance, apply_redirect, use_pending and latch_pending.
- The PC, pend_target and counter datapath stays in the top module.

Test Plan:
- Boot: release reset with stall=0 and no jumps.
  - Cycle 1: pc_f=0x2000, kill_x=1.
  - Cycle 2: pc_f=0x2004, pc_x=0x2000, kill_x=1.
  - Cycle 3: pc_f=0x2008, pc_x=0x2004, kill_x=0.
- Simple redirect: in RUN with pc_f=0x2010, pc_x=0x200C, kill_x=0, assert jump=1, jump_target=0x3002, stall=0.
  - Next cycle: pc_f=0x3000, pc_x=0x2010, kill_x=1, redirect_cnt=1.
  - Following cycle: pc_x=0x3000, kill_x=0, pc_f=0x3004.
- Killed jump: with kill_x=1, assert jump=1, jump_target=0x4000 -> pc_f advances by 4 and redirect_cnt is unchanged.
- Stalled redirect: jump=1, target=0x5000, stall=1 for 3 cycles, during which jump=0 and target=0x6000 from cycle 2.
  - pc_f and pc_x hold and state=PEND.
  - First cycle after stall drops: pc_f=0x5000, kill_x=1, redirect_cnt incremented by exactly 1.
- Reset in PEND: reach PEND with target 0x5000, pulse reset_n low mid-cycle.
  - Outputs go to reset values asynchronously.
  - After release: fetch resumes at 0x2000 and 0x5000 never appears on pc_f.
- Wrap: force pc_f=0xFFFF_FFFC in RUN with no jump -> next pc_f=0x0000_0000. Force redirect_cnt=0xFFFF_FFFF, then one redirect -> redirect_cnt=0.
